// File: rtl/alu_operations.sv
// Shared ALU operation encoding used by the control unit and the ALU.
package alu_operations;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_operation_t;

endpackage

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle sequencer for the tiny RV32I core: latches the fetched instruction,
// decodes it into the datapath control bundle and walks FETCH/DECODE/EXECUTE/
// MEMORY/WRITEBACK with ready handshakes to instruction and data memory.
module multi_cycle_control_unit
  import alu_operations::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned RETIRED_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_ready,
  input  logic [31:0]              instruction_in,
  input  logic                     memory_ready,
  input  logic                     branch_condition_met,
  output logic                     fetch_request,
  output logic                     memory_request,
  output logic [31:0]              instruction,
  output logic                     branch,
  output logic                     alu_operand_1_source,
  output logic                     alu_operand_2_source,
  output alu_operation_t           alu_operation,
  output logic                     memory_write_enable,
  output logic                     register_write_enable,
  output logic [1:0]               register_write_data_source,
  output logic                     pc_write_enable,
  output logic                     pc_select,
  output logic                     trap,
  output logic [RETIRED_WIDTH-1:0] instructions_retired
);

  localparam int unsigned WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;

  typedef enum logic [3:0] {
    CLASS_ILLEGAL, CLASS_OP, CLASS_OP_IMM, CLASS_LOAD, CLASS_STORE,
    CLASS_BRANCH, CLASS_JAL, CLASS_JALR, CLASS_LUI, CLASS_AUIPC
  } instr_class_t;

  state_t                  state;
  instr_class_t            instr_class;
  logic [WAIT_WIDTH-1:0]   wait_count;
  logic                    timeout_hit;
  logic                    condition;
  logic                    condition_q;
  logic                    bundle_active;
  logic                    drive;
  logic                    writes_rd;
  logic                    rd_write;
  logic                    is_memory_access;
  logic                    is_store;
  logic                    fetch_request_q;
  logic                    memory_request_q;
  logic                    memory_write_enable_q;
  logic                    register_write_enable_q;
  logic                    pc_write_enable_q;
  logic                    pc_select_q;
  logic                    bundle_branch;
  logic                    bundle_op1;
  logic                    bundle_op2;
  alu_operation_t          bundle_op;
  logic [1:0]              bundle_wsrc;

  function automatic alu_operation_t alu_for_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Classify the latched instruction by opcode.
  always_comb begin
    instr_class = CLASS_ILLEGAL;
    case (instruction[6:0])
      OPCODE_OP:     instr_class = CLASS_OP;
      OPCODE_OP_IMM: instr_class = CLASS_OP_IMM;
      OPCODE_LOAD:   instr_class = CLASS_LOAD;
      OPCODE_STORE:  instr_class = CLASS_STORE;
      OPCODE_BRANCH: instr_class = CLASS_BRANCH;
      OPCODE_JAL:    instr_class = CLASS_JAL;
      OPCODE_JALR:   instr_class = CLASS_JALR;
      OPCODE_LUI:    instr_class = CLASS_LUI;
      OPCODE_AUIPC:  instr_class = CLASS_AUIPC;
      default:       instr_class = CLASS_ILLEGAL;
    endcase
  end

  // Control bundle decoded from the latched instruction.
  always_comb begin
    bundle_branch = 1'b0;
    bundle_op1    = 1'b0;
    bundle_op2    = 1'b0;
    bundle_op     = ALU_ADD;
    bundle_wsrc   = 2'd0;
    writes_rd     = 1'b0;
    case (instr_class)
      CLASS_OP: begin
        bundle_op = alu_for_funct3(instruction[14:12], instruction[30]);
        writes_rd = 1'b1;
      end
      CLASS_OP_IMM: begin
        bundle_op2 = 1'b1;
        bundle_op  = (instruction[14:12] == 3'b000) ? ALU_ADD
                   : alu_for_funct3(instruction[14:12], instruction[30]);
        writes_rd  = 1'b1;
      end
      CLASS_LOAD: begin
        bundle_op2  = 1'b1;
        bundle_wsrc = 2'd2;
        writes_rd   = 1'b1;
      end
      CLASS_STORE: bundle_op2 = 1'b1;
      CLASS_BRANCH: begin
        bundle_branch = 1'b1;
        case (instruction[14:13])
          2'b10:   bundle_op = ALU_SLT;
          2'b11:   bundle_op = ALU_SLTU;
          default: bundle_op = ALU_SUB;
        endcase
      end
      CLASS_JAL: begin
        bundle_branch = 1'b1;
        bundle_op1    = 1'b1;
        bundle_op2    = 1'b1;
        bundle_wsrc   = 2'd3;
        writes_rd     = 1'b1;
      end
      CLASS_JALR: begin
        bundle_branch = 1'b1;
        bundle_op2    = 1'b1;
        bundle_wsrc   = 2'd3;
        writes_rd     = 1'b1;
      end
      CLASS_LUI: begin
        bundle_op2  = 1'b1;
        bundle_wsrc = 2'd1;
        writes_rd   = 1'b1;
      end
      CLASS_AUIPC: begin
        bundle_op1 = 1'b1;
        bundle_op2 = 1'b1;
        writes_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_write         = writes_rd && (instruction[11:7] != 5'd0);
  assign is_memory_access = (instr_class == CLASS_LOAD) || (instr_class == CLASS_STORE);
  assign is_store         = (instr_class == CLASS_STORE);
  assign condition        = (instr_class == CLASS_JAL) || (instr_class == CLASS_JALR) ||
                            ((instr_class == CLASS_BRANCH) && branch_condition_met);
  assign timeout_hit      = (TIMEOUT_CYCLES != 0) &&
                            (wait_count == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Sequencer: state, latched instruction, registered strobes, timeout and retire count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= FETCH;
      instruction             <= '0;
      trap                    <= 1'b0;
      instructions_retired    <= '0;
      wait_count              <= '0;
      condition_q             <= 1'b0;
      bundle_active           <= 1'b0;
      // Preloaded for the FETCH state entered on release; masked while reset is high.
      fetch_request_q         <= 1'b1;
      memory_request_q        <= 1'b0;
      memory_write_enable_q   <= 1'b0;
      register_write_enable_q <= 1'b0;
      pc_write_enable_q       <= 1'b0;
      pc_select_q             <= 1'b0;
    end else begin
      wait_count <= '0;
      case (state)
        FETCH: begin
          if (fetch_ready) begin
            instruction     <= instruction_in;
            fetch_request_q <= 1'b0;
            state           <= DECODE;
          end else if (timeout_hit) begin
            fetch_request_q <= 1'b0;
            trap            <= 1'b1;
            state           <= TRAP;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        DECODE: begin
          if (instr_class == CLASS_ILLEGAL) begin
            trap  <= 1'b1;
            state <= TRAP;
          end else begin
            bundle_active <= 1'b1;
            state         <= EXECUTE;
          end
        end
        EXECUTE: begin
          condition_q <= condition;
          if (is_memory_access) begin
            memory_request_q      <= 1'b1;
            memory_write_enable_q <= is_store;
            state                 <= MEMORY;
          end else begin
            pc_write_enable_q       <= 1'b1;
            register_write_enable_q <= rd_write;
            pc_select_q             <= condition;
            state                   <= WRITEBACK;
          end
        end
        MEMORY: begin
          if (memory_ready) begin
            memory_request_q        <= 1'b0;
            memory_write_enable_q   <= 1'b0;
            pc_write_enable_q       <= 1'b1;
            register_write_enable_q <= rd_write;
            pc_select_q             <= condition_q;
            state                   <= WRITEBACK;
          end else if (timeout_hit) begin
            memory_request_q      <= 1'b0;
            memory_write_enable_q <= 1'b0;
            bundle_active         <= 1'b0;
            trap                  <= 1'b1;
            state                 <= TRAP;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        WRITEBACK: begin
          pc_write_enable_q       <= 1'b0;
          register_write_enable_q <= 1'b0;
          pc_select_q             <= 1'b0;
          bundle_active           <= 1'b0;
          instructions_retired    <= instructions_retired + 1'b1;
          fetch_request_q         <= 1'b1;
          state                   <= FETCH;
        end
        default: begin
          trap  <= 1'b1;
          state <= TRAP;
        end
      endcase
    end
  end

  // Reset masks every strobe and the bundle in the cycle it is asserted.
  assign drive                      = bundle_active & ~reset;
  assign fetch_request              = fetch_request_q & ~reset;
  assign memory_request             = memory_request_q & ~reset;
  assign memory_write_enable        = memory_write_enable_q & ~reset;
  assign register_write_enable      = register_write_enable_q & ~reset;
  assign pc_write_enable            = pc_write_enable_q & ~reset;
  assign pc_select                  = pc_select_q & ~reset;
  assign branch                     = bundle_branch & drive;
  assign alu_operand_1_source       = bundle_op1 & drive;
  assign alu_operand_2_source       = bundle_op2 & drive;
  assign alu_operation              = drive ? bundle_op : ALU_ADD;
  assign register_write_data_source = drive ? bundle_wsrc : 2'd0;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: the driver pushes the expected
// writeback of every instruction it issues; the monitor pops and compares at
// each writeback strobe.
module tb_multi_cycle_control_unit;
  import alu_operations::*;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned RW      = 8;

  logic          clock = 1'b0;
  logic          reset, fetch_ready, memory_ready, branch_condition_met;
  logic [31:0]   instruction_in, instruction;
  logic          fetch_request, memory_request, branch, op1_src, op2_src;
  alu_operation_t alu_operation;
  logic          memory_write_enable, register_write_enable, pc_write_enable, pc_select, trap;
  logic [1:0]    wsrc;
  logic [RW-1:0] instructions_retired;

  multi_cycle_control_unit #(.TIMEOUT_CYCLES(TIMEOUT), .RETIRED_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .fetch_ready(fetch_ready), .instruction_in(instruction_in),
    .memory_ready(memory_ready), .branch_condition_met(branch_condition_met),
    .fetch_request(fetch_request), .memory_request(memory_request), .instruction(instruction),
    .branch(branch), .alu_operand_1_source(op1_src), .alu_operand_2_source(op2_src),
    .alu_operation(alu_operation), .memory_write_enable(memory_write_enable),
    .register_write_enable(register_write_enable), .register_write_data_source(wsrc),
    .pc_write_enable(pc_write_enable), .pc_select(pc_select), .trap(trap),
    .instructions_retired(instructions_retired));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]    instr;
    logic           rwe;
    logic [1:0]     wsrc;
    logic           op1, op2, br, pc_sel;
    alu_operation_t op;
    logic [RW-1:0]  retired;
    int             latency, mreq_cycles, mwe_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   model_retired = 0;
  logic [6:0] legal_opcodes [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic alu_operation_t base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;   3'd1: return ALU_SLL;  3'd2: return ALU_SLT;  3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;   3'd5: return ALU_SRL;  3'd6: return ALU_OR;   default: return ALU_AND;
    endcase
  endfunction

  // Reference: expected writeback view of one instruction given its wait pattern.
  function automatic exp_t model(input logic [31:0] ins, input int fw, input int mw, input logic bcm);
    exp_t e;
    logic [2:0] f3 = ins[14:12];
    logic writes = 1'b0, mem = 1'b0, store = 1'b0;
    e.instr = ins; e.rwe = 0; e.wsrc = 0; e.op1 = 0; e.op2 = 0; e.br = 0; e.pc_sel = 0;
    e.op = ALU_ADD; e.retired = '0;
    case (ins[6:0])
      7'h33: begin writes = 1; e.op = base_op(f3);
               if (ins[30] && f3 == 3'd0) e.op = ALU_SUB;
               if (ins[30] && f3 == 3'd5) e.op = ALU_SRA; end
      7'h13: begin writes = 1; e.op2 = 1; e.op = base_op(f3);
               if (ins[30] && f3 == 3'd5) e.op = ALU_SRA; end
      7'h03: begin writes = 1; e.op2 = 1; e.wsrc = 2; mem = 1; end
      7'h23: begin e.op2 = 1; mem = 1; store = 1; end
      7'h63: begin e.br = 1; e.pc_sel = bcm;
               e.op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT); end
      7'h6F: begin writes = 1; e.br = 1; e.op1 = 1; e.op2 = 1; e.wsrc = 3; e.pc_sel = 1; end
      7'h67: begin writes = 1; e.br = 1; e.op2 = 1; e.wsrc = 3; e.pc_sel = 1; end
      7'h37: begin writes = 1; e.op2 = 1; e.wsrc = 1; end
      default: begin writes = 1; e.op1 = 1; e.op2 = 1; end
    endcase
    e.rwe         = writes && (ins[11:7] != 5'd0);
    e.latency     = 4 + fw + (mem ? 1 + mw : 0);
    e.mreq_cycles = mem ? mw + 1 : 0;
    e.mwe_cycles  = store ? mw + 1 : 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_fetch();
    int budget = 0;
    fetch_ready = 0; memory_ready = 0;
    while (!fetch_request && budget < 64) begin step(); budget++; end
    check("fetch_request_seen", 32'(fetch_request), 1);
  endtask

  // Issues one instruction; ready noise outside the matching wait state must be ignored.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bcm);
    exp_t e;
    e = model(ins, fw, mw, bcm);
    e.retired = RW'(model_retired);
    sb.push_back(e);
    model_retired++;
    wait_fetch();
    repeat (fw) step();
    fetch_ready = 1; instruction_in = ins; step();
    fetch_ready = 1'($urandom); memory_ready = 1'($urandom); instruction_in = $urandom;
    branch_condition_met = ~bcm; step();
    fetch_ready = 1'($urandom); memory_ready = 1'($urandom); branch_condition_met = bcm; step();
    branch_condition_met = ~bcm; fetch_ready = 1'($urandom);
    if (e.mreq_cycles != 0) begin
      memory_ready = 0; repeat (mw) step();
      memory_ready = 1; step();
    end
    memory_ready = 1'($urandom); step();
    fetch_ready = 0; memory_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1; fetch_ready = 0; memory_ready = 0; #1;
    check("strobes_during_reset",
          32'({fetch_request, memory_request, memory_write_enable, register_write_enable, pc_write_enable}), 0);
    step();
    reset = 0; #1;
    model_retired = 0;
    check("fetch_after_reset", 32'(fetch_request), 1);
    check("trap_after_reset", 32'(trap), 0);
    check("retired_after_reset", 32'(instructions_retired), 0);
  endtask

  task automatic check_trapped(input string name);
    fetch_ready = 1; memory_ready = 1; instruction_in = $urandom;
    repeat (4) begin
      step();
      check({name, "_trap_sticky"}, 32'(trap), 1);
      check({name, "_strobes_low"},
            32'({fetch_request, memory_request, memory_write_enable, register_write_enable,
                 pc_write_enable, branch}), 0);
    end
  endtask

  // Monitor: measures each instruction and compares at its writeback strobe.
  int cyc = 0, start_cyc = 0, mreq_n = 0, mwe_n = 0;
  bit in_instr = 0;
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      in_instr = 0; mreq_n = 0; mwe_n = 0;
    end else begin
      cyc++;
      if (fetch_request) begin
        if (!in_instr) begin in_instr = 1; start_cyc = cyc; mreq_n = 0; mwe_n = 0; end
        check("bundle_idle_in_fetch", 32'({branch, op1_src, op2_src, 4'(alu_operation), wsrc}), 0);
      end
      if (memory_request) mreq_n++;
      if (memory_write_enable) mwe_n++;
      if (pc_write_enable) begin
        if (sb.size() == 0) check("unexpected_writeback", 32'(pc_write_enable), 0);
        else begin
          e = sb.pop_front();
          check("wb_instruction", instruction, e.instr);
          check("wb_reg_we", 32'(register_write_enable), 32'(e.rwe));
          check("wb_data_src", 32'(wsrc), 32'(e.wsrc));
          check("wb_op1_src", 32'(op1_src), 32'(e.op1));
          check("wb_op2_src", 32'(op2_src), 32'(e.op2));
          check("wb_alu_op", 32'(alu_operation), 32'(e.op));
          check("wb_branch", 32'(branch), 32'(e.br));
          check("wb_pc_select", 32'(pc_select), 32'(e.pc_sel));
          check("wb_retired", 32'(instructions_retired), 32'(e.retired));
          check("latency", cyc - start_cyc + 1, e.latency);
          check("mem_request_cycles", mreq_n, e.mreq_cycles);
          check("mem_write_cycles", mwe_n, e.mwe_cycles);
        end
        in_instr = 0;
      end else begin
        check("reg_we_outside_wb", 32'(register_write_enable), 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] ins;
    reset = 1; fetch_ready = 0; memory_ready = 0; instruction_in = '0; branch_condition_met = 0;
    step(); step();
    check("instruction_reset", instruction, 0);
    do_reset();

    run_instr(32'h00500093, 0, 0, 1'b0);   // ADDI x1,x0,5
    run_instr(32'h00112023, 0, 3, 1'b0);   // SW x1,0(x2), memory ready after 3 waits
    run_instr(32'h00208063, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00208033, 1, 0, 1'b0);   // ADD x0,x1,x2
    run_instr(32'h008000EF, 2, 0, 1'b0);   // JAL x1,8
    run_instr(32'h00012083, TIMEOUT - 1, TIMEOUT - 1, 1'b0);  // LW, ready on the limit cycle

    for (int i = 0; i < 300; i++) begin
      ins = {25'($urandom), legal_opcodes[$urandom_range(0, 8)]};
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end
    check("retired_wrap", 32'(instructions_retired), 32'(RW'(model_retired)));

    // Illegal opcode.
    wait_fetch();
    fetch_ready = 1; instruction_in = 32'h0000007F; step();
    fetch_ready = 0; step();
    check("illegal_trap", 32'(trap), 1);
    check_trapped("illegal");
    do_reset();

    // Fetch timeout.
    wait_fetch();
    repeat (TIMEOUT - 1) step();
    check("fetch_wait_no_trap", 32'({trap, fetch_request}), 1);
    step();
    check("fetch_timeout_trap", 32'({trap, fetch_request}), 2);
    check_trapped("fetch_timeout");
    do_reset();

    // Memory timeout on a load.
    wait_fetch();
    fetch_ready = 1; instruction_in = 32'h00012083; step();
    fetch_ready = 0; step(); step();
    repeat (TIMEOUT - 1) step();
    check("mem_wait_no_trap", 32'({trap, memory_request}), 1);
    step();
    check("mem_timeout_trap", 32'({trap, memory_request}), 2);
    check_trapped("mem_timeout");
    do_reset();

    // Reset in the middle of a store's memory phase.
    wait_fetch();
    fetch_ready = 1; instruction_in = 32'h00112023; step();
    fetch_ready = 0; step(); step(); step(); step();
    check("store_write_active", 32'({memory_request, memory_write_enable}), 3);
    do_reset();
    check("store_aborted", 32'(memory_write_enable), 0);

    run_instr(32'h00500093, 0, 0, 1'b0);
    repeat (3) step();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
